cmp_nic: RTL and testbench
==========================

Name: cmp_nic

Overview:
- Per-node network interface controller between one Cardinal processor's NIC port and its ring/mesh router port.
- Instantiated four times inside cmp, one per node.
- Processor side: 2-bit register address space; status words polled with load instructions.
- Network side: one single-entry input channel buffer and one single-entry output channel buffer, each using a send/ready handshake.

Parameters:
- DATA_W, 64, packet and processor data width (bit 0 = MSB, big-endian vectors [0:DATA_W-1]).
- ADDR_W, 2, processor-side register address width.

Ports:
- CLK  input  1  system clock, all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset.
- addr_nic  input  [0:1]  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- din_nic  input  [0:63]  processor write data.
- dout_nic  output  [0:63]  processor read data (combinational).
- nicEn  input  1  access enable.
- nicWrEn  input  1  1 = write, 0 = read (valid only with nicEn).
- net_si  input  1  router has packet for NIC.
- net_ri  output  1  NIC can accept packet.
- net_di  input  [0:63]  packet from router.
- net_so  output  1  NIC sending packet to router.
- net_ro  input  1  router can accept packet.
- net_do  output  [0:63]  packet to router.
- net_polarity  input  1  router VC phase (used only with the optional feature).

Behaviour:
- Reset (RESET=0, async): in_full=0, out_full=0, both data buffers = 0.
  - Outputs during reset: dout_nic=0, net_ri=0, net_so=0, net_do=0.
  - net_ri rises in the first cycle after deassertion.
  - Reset mid-transfer discards any held packet.
- Input channel:
  - net_ri = RESET & ~in_full.
  - Posedge with net_si & net_ri: in_buf <= net_di, in_full <= 1.
  - net_si while full: ignored, no overwrite.
- Processor read, addr 00 (nicEn & ~nicWrEn):
  - dout_nic = in_buf in the same cycle.
  - At posedge, in_full <= 0 if it was 1.
  - Read while empty: returns in_buf (stale), no state change.
  - No accept-and-drain in the same cycle: net_ri is 0 while full, so a new packet is accepted earliest in the cycle after the drain edge.
- Processor read, addr 01: dout_nic = {63'b0, in_full}, bit 63 = full flag.
- Processor read, addr 11: dout_nic = {63'b0, out_full}.
- Processor read, addr 10: dout_nic = 0.
- Idle (nicEn=0): dout_nic = 0.
- Processor write, addr 10 (nicEn & nicWrEn):
  - If out_full=0 at cycle start: out_buf <= din_nic, out_full <= 1.
  - If full: write dropped silently.
  - No bypass: a write in the same cycle as a send completion is dropped. Software polls addr 11 first.
- Writes to 00, 01, 11: ignored.
- Output channel:
  - net_so = out_full & net_ro; net_do = out_buf.
  - Posedge with net_so: out_full <= 0.
  - Latency: processor write -> net_so earliest the next cycle.
  - Router packet -> readable at addr 00 the next cycle.
- Simultaneous processor read of addr 00 and router send: independent channels, both complete.

Optional Feature:
- Macro: CMP_NIC_POLARITY_EN.
- Defined: net_so = out_full & net_ro & (out_buf[0] == net_polarity). Packet VC bit 0 must match the router phase, otherwise the packet is held until the phase matches.
- Undefined: net_polarity is unused and the send rule above applies.

Decomposition:
- Package cmp_nic_pkg:
  - address constants NIC_ADDR_IN_BUF=2'b00, NIC_ADDR_IN_STAT=2'b01, NIC_ADDR_OUT_BUF=2'b10, NIC_ADDR_OUT_STAT=2'b11.
  - DATA_W, and the status-bit index STAT_BIT=63.
- Sub-module nic_chan_buf:
  - one-entry buffer with a full flag and ports load/drain/data_in/data_out/full.
  - Instantiated twice, for the input and output channels.

Test Plan:
- Reset and idle:
  - Hold RESET=0 for 3 cycles -> net_ri=0, net_so=0, dout_nic=0.
  - Release -> net_ri=1 the next cycle; reads of addr 01 and 11 return 0.
- Receive:
  - net_si=1, net_di=64'hDEAD_BEEF_0000_0001 for one cycle -> net_ri=0 and addr 01 reads 64'h1.
  - Read addr 00 -> returns DEAD_BEEF_0000_0001; the next cycle addr 01 reads 0 and net_ri=1.
- Receive backpressure:
  - With the buffer full, present net_di=64'h2 -> not latched; a later addr 00 read still returns ...0001.
- Send:
  - Write addr 10 = 64'h0123_4567_89AB_CDEF with net_ro=0 -> addr 11 reads 1, net_so=0.
  - Set net_ro=1 -> net_so=1, net_do=0123_4567_89AB_CDEF for exactly one cycle, then addr 11 reads 0.
- Write while full:
  - Second write 64'h5 while out_full=1 -> dropped; the sent packet is still ...CDEF.
- Mid-operation reset:
  - Assert RESET low while both buffers are full -> both flags 0 immediately (async), net_so drops in the same time step.

Source files
------------

// File: rtl/cmp_nic_pkg.sv
// cmp_nic_pkg: shared widths, register map and status-word helper for the per-node NIC.
package cmp_nic_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 2;
  localparam int STAT_BIT = 63;
  localparam logic [0:ADDR_W-1] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [0:ADDR_W-1] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [0:ADDR_W-1] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [0:ADDR_W-1] NIC_ADDR_OUT_STAT = 2'b11;
  function automatic logic [0:DATA_W-1] stat_word(input logic f);
    logic [0:DATA_W-1] w;
    w = '0;
    w[STAT_BIT] = f;
    return w;
  endfunction
endpackage

// File: rtl/cmp_nic_if.sv
// cmp_nic_if: processor register port plus router send/ready channels of one NIC.
interface cmp_nic_if;
  import cmp_nic_pkg::*;
  logic [0:ADDR_W-1] addr_nic;
  logic [0:DATA_W-1] din_nic;
  logic [0:DATA_W-1] dout_nic;
  logic              nicEn;
  logic              nicWrEn;
  logic              net_si;
  logic              net_ri;
  logic [0:DATA_W-1] net_di;
  logic              net_so;
  logic              net_ro;
  logic [0:DATA_W-1] net_do;
  logic              net_polarity;
  modport master (
    output addr_nic, din_nic, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    input  dout_nic, net_ri, net_so, net_do
  );
  modport slave (
    input  addr_nic, din_nic, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    output dout_nic, net_ri, net_so, net_do
  );
endinterface

// File: rtl/cmp_nic_chan_buf.sv
// nic_chan_buf: single-entry channel buffer with full flag; load wins over drain.
module nic_chan_buf
  import cmp_nic_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic         drain,
  input  logic [0:W-1] data_in,
  output logic [0:W-1] data_out,
  output logic         full
);
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      data_out <= '0;
      full     <= 1'b0;
    end else begin
      if (load) data_out <= data_in;
      full <= load | (full & ~drain);
    end
endmodule

// File: rtl/cmp_nic.sv
// cmp_nic: per-node NIC bridging processor register accesses to router channels.
// Define CMP_NIC_POLARITY_EN to hold sends until packet VC bit 0 matches net_polarity.
module cmp_nic
  import cmp_nic_pkg::*;
(
  input  logic      CLK,
  input  logic      RESET,
  cmp_nic_if.slave  bus
);
  logic [0:DATA_W-1] in_buf, out_buf;
  logic              in_full, out_full, rd, wr;
  assign rd = bus.nicEn & ~bus.nicWrEn;
  assign wr = bus.nicEn & bus.nicWrEn;
  assign bus.net_ri = RESET & ~in_full;
`ifdef CMP_NIC_POLARITY_EN
  assign bus.net_so = out_full & bus.net_ro & (out_buf[0] == bus.net_polarity);
`else
  assign bus.net_so = out_full & bus.net_ro;
`endif
  assign bus.net_do = out_buf;
  assign bus.dout_nic = !rd                                  ? '0 :
                        bus.addr_nic == NIC_ADDR_IN_BUF   ? in_buf :
                        bus.addr_nic == NIC_ADDR_IN_STAT  ? stat_word(in_full) :
                        bus.addr_nic == NIC_ADDR_OUT_STAT ? stat_word(out_full) : '0;
  // net_ri is low while full, so accept and drain can never coincide
  nic_chan_buf #(.W(DATA_W)) u_in (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (bus.net_si & bus.net_ri),
    .drain    (rd & (bus.addr_nic == NIC_ADDR_IN_BUF) & in_full),
    .data_in  (bus.net_di),
    .data_out (in_buf),
    .full     (in_full)
  );
  nic_chan_buf #(.W(DATA_W)) u_out (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (wr & (bus.addr_nic == NIC_ADDR_OUT_BUF) & ~out_full),
    .drain    (bus.net_so),
    .data_in  (bus.din_nic),
    .data_out (out_buf),
    .full     (out_full)
  );
endmodule

// File: tb/tb_cmp_nic.sv
// tb_cmp_nic: directed-vector bench for cmp_nic with hand-computed expectations.
module tb_cmp_nic;
  import cmp_nic_pkg::*;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  cmp_nic_if bus();
  cmp_nic dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [0:63] got, input logic [0:63] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rd(input logic [0:1] a);
    bus.nicEn = 1'b1;
    bus.nicWrEn = 1'b0;
    bus.addr_nic = a;
  endtask
  task automatic wr(input logic [0:1] a, input logic [0:63] d);
    bus.nicEn = 1'b1;
    bus.nicWrEn = 1'b1;
    bus.addr_nic = a;
    bus.din_nic = d;
  endtask
  task automatic idle();
    bus.nicEn = 1'b0;
    bus.nicWrEn = 1'b0;
    bus.addr_nic = 2'b00;
    bus.din_nic = '0;
  endtask
  task automatic step();
    @(negedge CLK);
    #1;
  endtask
  initial begin
    idle();
    bus.net_si = 1'b0;
    bus.net_di = '0;
    bus.net_ro = 1'b1;
    bus.net_polarity = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_ri", 64'(bus.net_ri), 64'd0);
    chk("rst_so", 64'(bus.net_so), 64'd0);
    chk("rst_dout", bus.dout_nic, 64'd0);
    chk("rst_do", bus.net_do, 64'd0);
    bus.net_ro = 1'b0;
    RESET = 1'b1;
    step();
    chk("rel_ri", 64'(bus.net_ri), 64'd1);
    rd(NIC_ADDR_IN_STAT);
    #1 chk("rel_in_stat", bus.dout_nic, 64'd0);
    rd(NIC_ADDR_OUT_STAT);
    #1 chk("rel_out_stat", bus.dout_nic, 64'd0);
    idle();
    #1 chk("idle_dout", bus.dout_nic, 64'd0);
    // receive one packet
    bus.net_si = 1'b1;
    bus.net_di = 64'hDEAD_BEEF_0000_0001;
    step();
    bus.net_si = 1'b0;
    chk("rx_ri_low", 64'(bus.net_ri), 64'd0);
    rd(NIC_ADDR_IN_STAT);
    #1 chk("rx_in_stat", bus.dout_nic, 64'd1);
    idle();
    // backpressure: a second packet while full must not be latched
    bus.net_si = 1'b1;
    bus.net_di = 64'h2;
    step();
    bus.net_si = 1'b0;
    rd(NIC_ADDR_IN_STAT);
    #1 chk("bp_in_stat", bus.dout_nic, 64'd1);
    rd(NIC_ADDR_IN_BUF);
    #1 chk("rx_read", bus.dout_nic, 64'hDEAD_BEEF_0000_0001);
    step();
    rd(NIC_ADDR_IN_STAT);
    #1 chk("drain_in_stat", bus.dout_nic, 64'd0);
    chk("drain_ri", 64'(bus.net_ri), 64'd1);
    rd(NIC_ADDR_IN_BUF);
    #1 chk("stale_read", bus.dout_nic, 64'hDEAD_BEEF_0000_0001);
    rd(NIC_ADDR_OUT_BUF);
    #1 chk("out_buf_read", bus.dout_nic, 64'd0);
    // send with router not ready
    wr(NIC_ADDR_OUT_BUF, 64'h0123_4567_89AB_CDEF);
    step();
    rd(NIC_ADDR_OUT_STAT);
    #1 chk("tx_out_stat", bus.dout_nic, 64'd1);
    chk("tx_so_held", 64'(bus.net_so), 64'd0);
    wr(NIC_ADDR_OUT_BUF, 64'h5);
    step();
    wr(NIC_ADDR_IN_BUF, 64'hFFFF);
    step();
    idle();
    bus.net_ro = 1'b1;
    #1 chk("tx_so", 64'(bus.net_so), 64'd1);
    chk("tx_do", bus.net_do, 64'h0123_4567_89AB_CDEF);
    step();
    bus.net_ro = 1'b0;
    chk("tx_so_done", 64'(bus.net_so), 64'd0);
    chk("tx_do_kept", bus.net_do, 64'h0123_4567_89AB_CDEF);
    rd(NIC_ADDR_OUT_STAT);
    #1 chk("tx_done_stat", bus.dout_nic, 64'd0);
    rd(NIC_ADDR_IN_STAT);
    #1 chk("wr_in_ignored", bus.dout_nic, 64'd0);
    // fill both, then drain and send in the same cycle
    wr(NIC_ADDR_OUT_BUF, 64'h8000_0000_0000_00AA);
    bus.net_si = 1'b1;
    bus.net_di = 64'h0000_0000_0000_0077;
    step();
    bus.net_si = 1'b0;
    rd(NIC_ADDR_IN_BUF);
    bus.net_ro = 1'b1;
    #1 chk("sim_read", bus.dout_nic, 64'h77);
    chk("sim_so", 64'(bus.net_so), 64'd1);
    chk("sim_do", bus.net_do, 64'h8000_0000_0000_00AA);
    step();
    bus.net_ro = 1'b0;
    rd(NIC_ADDR_IN_STAT);
    #1 chk("sim_in_stat", bus.dout_nic, 64'd0);
    rd(NIC_ADDR_OUT_STAT);
    #1 chk("sim_out_stat", bus.dout_nic, 64'd0);
    // refill both and reset asynchronously mid-cycle
    wr(NIC_ADDR_OUT_BUF, 64'h0000_0000_0000_0099);
    bus.net_si = 1'b1;
    bus.net_di = 64'h55;
    step();
    bus.net_si = 1'b0;
    idle();
    bus.net_ro = 1'b1;
    #1 chk("pre_rst_so", 64'(bus.net_so), 64'd1);
    RESET = 1'b0;
    #1 chk("arst_so", 64'(bus.net_so), 64'd0);
    chk("arst_do", bus.net_do, 64'd0);
    chk("arst_ri", 64'(bus.net_ri), 64'd0);
    rd(NIC_ADDR_IN_STAT);
    #1 chk("arst_in_stat", bus.dout_nic, 64'd0);
    rd(NIC_ADDR_OUT_STAT);
    #1 chk("arst_out_stat", bus.dout_nic, 64'd0);
    rd(NIC_ADDR_IN_BUF);
    #1 chk("arst_in_buf", bus.dout_nic, 64'd0);
    idle();
    bus.net_ro = 1'b0;
    step();
    RESET = 1'b1;
    #1 chk("rerel_ri", 64'(bus.net_ri), 64'd1);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
